// File: rtl/i2s_frame_feeder_pkg.sv
// Shared defaults and helpers for the I2S frame feeder and its sample FIFO.
// The default widths and rates match those used by the downstream I2S transmitter.
package i2s_frame_feeder_pkg;

  localparam int DEF_BITSIZE    = 16;
  localparam int DEF_BCLK_HALF  = 2;
  localparam int DEF_SLOT_BITS  = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } lr_slot_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of stereo pairs; a push while full or a pop while empty is ignored.
// The head entry is presented combinationally so the consumer can register it on the pop edge.
module audio_sample_fifo
  import i2s_frame_feeder_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_BITSIZE,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = cnt_width(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (occ == OCC_FULL);
  assign empty     = (occ == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2s_frame_feeder.sv
// I2S upstream stage: derives bclk/lrclk from mclk, buffers producer pairs and updates
// the channel outputs mid-frame so they are stable around every lrclk falling edge.
module i2s_frame_feeder
  import i2s_frame_feeder_pkg::*;
#(
  parameter int BITSIZE    = DEF_BITSIZE,
  parameter int BCLK_HALF  = DEF_BCLK_HALF,
  parameter int SLOT_BITS  = DEF_SLOT_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic               confdone,
  input  logic [BITSIZE-1:0] in_left,
  input  logic [BITSIZE-1:0] in_right,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bclk,
  output logic               lrclk,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               underrun
);

  localparam int DIV_W = cnt_width(BCLK_HALF);
  localparam int BIT_W = cnt_width(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_nxt;
  logic                 div_wrap;
  logic                 bclk_fall;
  logic                 pop_point;
  lr_slot_e             slot_nxt;
  logic                 pop_p1;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*BITSIZE-1:0] head_pair;

  assign in_ready = ~fifo_full;

  audio_sample_fifo #(
    .WIDTH (2 * BITSIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (mclk),
    .reset     (reset),
    .push      (in_valid),
    .push_data ({in_left, in_right}),
    .pop       (pop_p1),
    .head_data (head_pair),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    bclk_fall   = confdone & div_wrap & bclk;
    bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    slot_nxt    = (bit_cnt_nxt >= SLOT_START) ? SLOT_RIGHT : SLOT_LEFT;
    pop_point   = bclk_fall & (slot_nxt == SLOT_RIGHT) & ~lrclk;
  end

  // Stage 0: clock generation; lrclk only moves together with a bclk falling edge.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
    end else if (!confdone) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) bclk <= ~bclk;
      if (bclk_fall) begin
        bit_cnt <= bit_cnt_nxt;
        lrclk   <= slot_nxt;
      end
    end
  end

  // Stage 1: pop request issued in the cycle lrclk has just risen.
  // Stage 2: head pair captured, or a one-cycle underrun flag when nothing is buffered.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      pop_p1     <= 1'b0;
      underrun   <= 1'b0;
      left_chan  <= '0;
      right_chan <= '0;
    end else begin
      pop_p1   <= pop_point;
      underrun <= pop_p1 & fifo_empty;
      if (pop_p1 && !fifo_empty) begin
        left_chan  <= head_pair[2*BITSIZE-1:BITSIZE];
        right_chan <= head_pair[BITSIZE-1:0];
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_feeder.sv
// Bench for i2s_frame_feeder: a cycle model of the clocks plus a queue scoreboard of pushed
// pairs, a table of per-frame vectors, and hand sequences for fill, confdone and reset cases.
module tb_i2s_frame_feeder;

  localparam int BITSIZE    = 16;
  localparam int BCLK_HALF  = 2;
  localparam int SLOT_BITS  = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 2 * SLOT_BITS * 2 * BCLK_HALF;

  logic               mclk = 1'b0;
  logic               reset;
  logic               confdone;
  logic [BITSIZE-1:0] in_left;
  logic [BITSIZE-1:0] in_right;
  logic               in_valid;
  logic               in_ready;
  logic               bclk;
  logic               lrclk;
  logic [BITSIZE-1:0] left_chan;
  logic [BITSIZE-1:0] right_chan;
  logic               underrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard / clock model state, advanced once per negedge.
  int           t = 0;
  logic [31:0]  sb_q[$];
  logic [15:0]  exp_l = '0;
  logic [15:0]  exp_r = '0;
  logic         exp_under = 1'b0;
  logic         lr_model_prev = 1'b0;
  logic         bclk_seen_prev = 1'b0;
  logic         lr_seen_prev = 1'b0;
  logic         cd_prev = 1'b0;

  typedef struct packed {
    logic        push;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] el;
    logic [15:0] er;
    logic        eu;
  } row_t;

  row_t        rows [6];
  logic [31:0] fill [5];

  i2s_frame_feeder #(
    .BITSIZE    (BITSIZE),
    .BCLK_HALF  (BCLK_HALF),
    .SLOT_BITS  (SLOT_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .confdone   (confdone),
    .in_left    (in_left),
    .in_right   (in_right),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .underrun   (underrun)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and clock model.
  always @(negedge mclk) begin
    logic exp_b;
    logic exp_lr;
    logic accept;
    if (reset) begin
      t = 0;
      sb_q.delete();
      exp_l = '0;
      exp_r = '0;
      exp_under = 1'b0;
      lr_model_prev = 1'b0;
      bclk_seen_prev = 1'b0;
      lr_seen_prev = 1'b0;
      cd_prev = 1'b0;
    end else begin
      exp_b  = ((t / BCLK_HALF) % 2) == 1;
      exp_lr = ((t / (2 * BCLK_HALF)) % (2 * SLOT_BITS)) >= SLOT_BITS;
      check("sb_bclk", {31'd0, bclk}, {31'd0, exp_b});
      check("sb_lrclk", {31'd0, lrclk}, {31'd0, exp_lr});
      check("sb_chans", {left_chan, right_chan}, {exp_l, exp_r});
      check("sb_underrun", {31'd0, underrun}, {31'd0, exp_under});
      check("sb_in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < FIFO_DEPTH});
      if (cd_prev && (lrclk !== lr_seen_prev))
        check("sb_lr_edge_on_bclk_fall", {30'd0, bclk_seen_prev, bclk}, 32'd2);
      accept = in_valid && (sb_q.size() < FIFO_DEPTH);
      exp_under = 1'b0;
      if (exp_lr && !lr_model_prev) begin
        if (sb_q.size() > 0) {exp_l, exp_r} = sb_q.pop_front();
        else exp_under = 1'b1;
      end
      if (accept) sb_q.push_back({in_left, in_right});
      lr_model_prev = exp_lr;
      bclk_seen_prev = bclk;
      lr_seen_prev = lrclk;
      cd_prev = confdone;
      t = confdone ? t + 1 : 0;
    end
  end

  task automatic wait_lr(input logic level, input string name);
    logic prev;
    int   n;
    bit   done;
    prev = lrclk;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge mclk);
      n++;
      if (lrclk === level && prev === ~level) begin
        done = 1'b1;
      end else if (n > 2 * FRAME) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: no lrclk edge within %0d cycles, required one", name, n);
        done = 1'b1;
      end
      prev = lrclk;
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    @(posedge mclk); #1;
    in_left = l;
    in_right = r;
    in_valid = 1'b1;
    @(posedge mclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic measure_period(input bit use_lr, output int period);
    logic prev;
    logic cur;
    int   n;
    bit   seen;
    prev = use_lr ? lrclk : bclk;
    n = 0;
    seen = 1'b0;
    period = -1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge mclk);
      cur = use_lr ? lrclk : bclk;
      if (seen) n++;
      if (!prev && cur) begin
        if (seen) begin
          period = n;
          break;
        end
        seen = 1'b1;
        n = 0;
      end
      prev = cur;
    end
  endtask

  initial begin
    int per;
    int k;
    int first_b;
    bit got;

    rows[0] = '{1'b1, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 1'b0};
    rows[1] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 16'hABCD, 1'b1};
    rows[2] = '{1'b1, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 1'b0};
    rows[3] = '{1'b1, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0};
    rows[4] = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0};
    rows[5] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b1};
    fill[0] = {16'h0101, 16'hF101};
    fill[1] = {16'h0202, 16'hF202};
    fill[2] = {16'h0303, 16'hF303};
    fill[3] = {16'h0404, 16'hF404};
    fill[4] = {16'h8000, 16'h7FFF};

    reset = 1'b1;
    confdone = 1'b0;
    in_valid = 1'b0;
    in_left = '0;
    in_right = '0;
    repeat (3) @(posedge mclk);
    #1 reset = 1'b0;
    @(negedge mclk);
    check("reset_bclk", {31'd0, bclk}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_chans", {left_chan, right_chan}, 32'd0);

    @(posedge mclk); #1 confdone = 1'b1;

    // Per-frame vectors: optional push in the left slot, then check the pop result.
    for (int i = 0; i < 6; i++) begin
      if (rows[i].push) push_pair(rows[i].l, rows[i].r);
      wait_lr(1'b1, "row_rise");
      @(negedge mclk);
      check("row_chans", {left_chan, right_chan}, {rows[i].el, rows[i].er});
      check("row_underrun", {31'd0, underrun}, {31'd0, rows[i].eu});
      @(negedge mclk);
      check("row_underrun_one_cycle", {31'd0, underrun}, 32'd0);
      wait_lr(1'b0, "row_fall");
      check("row_hold_at_fall", {left_chan, right_chan}, {rows[i].el, rows[i].er});
    end

    measure_period(1'b0, per);
    check("bclk_period", per, 4);
    measure_period(1'b1, per);
    check("lrclk_period", per, FRAME);

    // Fill the FIFO between pop points; the fifth pair waits for a pop.
    for (int i = 0; i < 5; i++) begin
      @(posedge mclk); #1;
      in_left = fill[i][31:16];
      in_right = fill[i][15:0];
      in_valid = 1'b1;
    end
    @(negedge mclk);
    check("fill_in_ready_low", {31'd0, in_ready}, 32'd0);
    got = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge mclk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("fill_ready_returns", {31'd0, got}, 32'd1);
    check("fill_ready_in_right_slot", {31'd0, lrclk}, 32'd1);
    check("fill_first_out", {left_chan, right_chan}, fill[0]);
    @(posedge mclk); #1 in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      wait_lr(1'b1, "fill_rise");
      @(negedge mclk);
      check("fill_order", {left_chan, right_chan}, fill[i]);
    end

    // confdone dropped at bit_cnt=40 with two pairs buffered, a third pushed while idle.
    wait_lr(1'b1, "cd_rise");
    @(posedge mclk); #1;
    in_left = 16'hC0DE;
    in_right = 16'h0001;
    in_valid = 1'b1;
    @(posedge mclk); #1;
    in_left = 16'hBEEF;
    in_right = 16'h0002;
    @(posedge mclk); #1 in_valid = 1'b0;
    repeat (29) @(posedge mclk);
    #1 confdone = 1'b0;
    @(negedge mclk);
    check("cd_lrclk_before_drop", {31'd0, lrclk}, 32'd1);
    @(negedge mclk);
    check("cd_idle_clocks", {30'd0, bclk, lrclk}, 32'd0);
    push_pair(16'hFACE, 16'h0003);
    repeat (10) @(posedge mclk);
    #1 confdone = 1'b1;
    k = 0;
    first_b = 0;
    got = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge mclk);
      k++;
      if (bclk && first_b == 0) first_b = k;
      if (lrclk) begin
        got = 1'b1;
        break;
      end
    end
    check("cd_first_bclk_rise", first_b - 1, BCLK_HALF);
    check("cd_left_slot_length", got ? k - 1 : -1, SLOT_BITS * 2 * BCLK_HALF);
    @(negedge mclk);
    check("cd_fifo_kept_0", {left_chan, right_chan}, {16'hC0DE, 16'h0001});
    wait_lr(1'b1, "cd_rise2");
    @(negedge mclk);
    check("cd_fifo_kept_1", {left_chan, right_chan}, {16'hBEEF, 16'h0002});
    wait_lr(1'b1, "cd_rise3");
    @(negedge mclk);
    check("cd_push_while_idle", {left_chan, right_chan}, {16'hFACE, 16'h0003});

    // Asynchronous reset mid-frame with bclk high and the FIFO full.
    for (int i = 0; i < 4; i++) begin
      @(posedge mclk); #1;
      in_left = fill[i][31:16];
      in_right = fill[i][15:0];
      in_valid = 1'b1;
    end
    @(posedge mclk); #1 in_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge mclk);
      if (bclk && lrclk && !in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("arst_precondition", {31'd0, got}, 32'd1);
    @(posedge mclk); #2 reset = 1'b1;
    #1;
    check("arst_clocks", {30'd0, bclk, lrclk}, 32'd0);
    check("arst_chans", {left_chan, right_chan}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_underrun", {31'd0, underrun}, 32'd0);
    @(posedge mclk); #1 reset = 1'b0;
    push_pair(16'h2468, 16'h1357);
    wait_lr(1'b1, "arst_rise");
    @(negedge mclk);
    check("arst_recover", {left_chan, right_chan}, {16'h2468, 16'h1357});
    check("arst_recover_no_underrun", {31'd0, underrun}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before the end of test");
    $fatal(1, "watchdog");
  end

endmodule
